// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin front end for one port of a byte-enabled BRAM.
// Optionally zero-fills the memory after reset before granting any access.
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int INIT_MEM   = 1
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    req_0,
    input  logic                    we_0,
    input  logic [DATA_WIDTH/8-1:0] be_0,
    input  logic [ADDR_WIDTH-1:0]   addr_0,
    input  logic [DATA_WIDTH-1:0]   wdata_0,
    output logic                    gnt_0,
    output logic                    rvalid_0,
    output logic [DATA_WIDTH-1:0]   rdata_0,

    input  logic                    req_1,
    input  logic                    we_1,
    input  logic [DATA_WIDTH/8-1:0] be_1,
    input  logic [ADDR_WIDTH-1:0]   addr_1,
    input  logic [DATA_WIDTH-1:0]   wdata_1,
    output logic                    gnt_1,
    output logic                    rvalid_1,
    output logic [DATA_WIDTH-1:0]   rdata_1,

    output logic                    init_done,

    output logic                    mem_readEnable,
    output logic                    mem_writeEnable,
    output logic [DATA_WIDTH/8-1:0] mem_writeByteEnable,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_writeData,
    input  logic [DATA_WIDTH-1:0]   mem_readData
);

    localparam int BE_W = DATA_WIDTH / 8;
    // Extra counter bit keeps the last-address compare unambiguous.
    localparam logic [ADDR_WIDTH:0] INIT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q,    state_d;
    logic [ADDR_WIDTH:0] init_cnt_q, init_cnt_d;
    logic                last_gnt_q, last_gnt_d;
    logic                rd_pend_q,  rd_pend_d;
    logic                rd_tag_q,   rd_tag_d;

    logic sel;
    logic run;
    logic granted;
    logic we_sel;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            last_gnt_q <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_tag_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        last_gnt_d = last_gnt_q;
        rd_pend_d  = 1'b0;
        rd_tag_d   = rd_tag_q;

        run = (state_q == S_RUN);
        // Contention goes to whoever was not served last; idle selects 0.
        sel     = (req_0 & req_1) ? ~last_gnt_q : req_1;
        granted = (req_0 | req_1) & run;
        we_sel  = sel ? we_1 : we_0;

        gnt_0 = req_0 & ~sel & run;
        gnt_1 = req_1 &  sel & run;

        mem_address         = sel ? addr_1  : addr_0;
        mem_writeData       = sel ? wdata_1 : wdata_0;
        mem_writeByteEnable = sel ? be_1    : be_0;
        mem_readEnable      = granted & ~we_sel;
        mem_writeEnable     = granted &  we_sel;

        case (state_q)
            S_INIT: begin
                if (INIT_MEM != 0) begin
                    mem_readEnable      = 1'b0;
                    mem_writeEnable     = 1'b1;
                    mem_writeByteEnable = {BE_W{1'b1}};
                    mem_address         = init_cnt_q[ADDR_WIDTH-1:0];
                    mem_writeData       = '0;
                    init_cnt_d          = init_cnt_q + CNT_ONE;
                    if (init_cnt_q == INIT_LAST) state_d = S_RUN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (granted) begin
                    last_gnt_d = sel;
                    rd_pend_d  = ~we_sel;
                    rd_tag_d   = sel;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // BRAM output is registered, so the response lines up with the tag register.
    assign rvalid_0  = rd_pend_q & ~rd_tag_q;
    assign rvalid_1  = rd_pend_q &  rd_tag_q;
    assign rdata_0   = rvalid_0 ? mem_readData : '0;
    assign rdata_1   = rvalid_1 ? mem_readData : '0;
    assign init_done = run;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural byte-enabled BRAM.
module tb_bram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int BW = DW / 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_0, we_0, req_1, we_1;
    logic [BW-1:0] be_0, be_1;
    logic [AW-1:0] addr_0, addr_1;
    logic [DW-1:0] wdata_0, wdata_1;
    logic          gnt_0, gnt_1, rvalid_0, rvalid_1, init_done;
    logic [DW-1:0] rdata_0, rdata_1;
    logic          mem_readEnable, mem_writeEnable;
    logic [BW-1:0] mem_writeByteEnable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writeData;
    logic [DW-1:0] mem_readData = '0;

    logic [DW-1:0] bram [0:(1<<AW)-1];

    int chk  = 0;
    int pass = 0;

    always #5 clock = ~clock;

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_MEM(1)) dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .we_0(we_0), .be_0(be_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
        .req_1(req_1), .we_1(we_1), .be_1(be_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
        .init_done(init_done),
        .mem_readEnable(mem_readEnable), .mem_writeEnable(mem_writeEnable),
        .mem_writeByteEnable(mem_writeByteEnable), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_readData(mem_readData)
    );

    // Registered-output BRAM port with per-byte write enables.
    always @(posedge clock) begin
        if (mem_writeEnable)
            for (int b = 0; b < BW; b++)
                if (mem_writeByteEnable[b]) bram[mem_address][8*b +: 8] <= mem_writeData[8*b +: 8];
        if (mem_readEnable) mem_readData <= bram[mem_address];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle;
        req_0 = 0; we_0 = 0; be_0 = '0; addr_0 = '0; wdata_0 = '0;
        req_1 = 0; we_1 = 0; be_1 = '0; addr_1 = '0; wdata_1 = '0;
    endtask

    task automatic wait_init(input int max_cyc, output int cyc);
        cyc = 0;
        while (!init_done && cyc < max_cyc) begin
            tick;
            cyc++;
        end
        chk++;
        if (init_done !== 1'b1) $display("FAIL init_timeout: init_done=%b after %0d cycles, required 1", init_done, cyc);
        else pass++;
    endtask

    task automatic test_reset;
        idle;
        reset = 1;
        req_0 = 1; req_1 = 1;
        repeat (3) tick;
        chk++;
        if ({gnt_0, gnt_1, init_done, rvalid_0, rvalid_1} !== 5'b0)
            $display("FAIL reset_outputs: gnt/init/rvalid=%b required 00000",
                     {gnt_0, gnt_1, init_done, rvalid_0, rvalid_1});
        else pass++;
        chk++;
        if (mem_address !== 4'd0 || mem_readEnable !== 1'b0)
            $display("FAIL reset_mem: addr=%0d re=%b required addr=0 re=0", mem_address, mem_readEnable);
        else pass++;
    endtask

    task automatic test_init;
        int writes;
        for (int k = 0; k < (1 << AW); k++) bram[k] = 32'hDEADBEEF;
        writes = 0;
        reset  = 0;
        #1;
        for (int k = 0; k < (1 << AW); k++) begin
            chk++;
            if ({mem_writeEnable, mem_readEnable, gnt_0, gnt_1, init_done} !== 5'b10000 ||
                mem_address !== AW'(k) || mem_writeData !== '0 || mem_writeByteEnable !== 4'hF)
                $display("FAIL init_cycle%0d: we/re/g0/g1/done=%b addr=%0d data=%h be=%h required 10000 addr=%0d data=0 be=f",
                         k, {mem_writeEnable, mem_readEnable, gnt_0, gnt_1, init_done},
                         mem_address, mem_writeData, mem_writeByteEnable, k);
            else pass++;
            if (mem_writeEnable) writes++;
            tick;
        end
        idle;
        #1;
        chk++;
        if (init_done !== 1'b1 || mem_writeEnable !== 1'b0)
            $display("FAIL init_done_rise: init_done=%b we=%b required 1 0", init_done, mem_writeEnable);
        else pass++;
        chk++;
        if (writes !== 16) $display("FAIL init_write_count: got %0d required 16", writes);
        else pass++;
        for (int k = 0; k < (1 << AW); k++) begin
            chk++;
            if (bram[k] !== 32'h0) $display("FAIL init_zero%0d: mem=%h required 0", k, bram[k]);
            else pass++;
        end
    endtask

    task automatic test_alternate;
        logic [1:0] exp_g;
        idle;
        req_0 = 1; we_0 = 1; addr_0 = 4'd1; wdata_0 = 32'h11111111; be_0 = 4'hF;
        #1;
        chk++;
        if ({gnt_0, gnt_1} !== 2'b10) $display("FAIL alt_setup_w0: gnt=%b required 10", {gnt_0, gnt_1});
        else pass++;
        tick; idle;
        req_1 = 1; we_1 = 1; addr_1 = 4'd2; wdata_1 = 32'h22222222; be_1 = 4'hF;
        #1;
        chk++;
        if ({gnt_0, gnt_1} !== 2'b01) $display("FAIL alt_setup_w1: gnt=%b required 01", {gnt_0, gnt_1});
        else pass++;
        tick; idle;
        req_0 = 1; addr_0 = 4'd1;
        req_1 = 1; addr_1 = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
            chk++;
            if ({gnt_0, gnt_1} !== exp_g) $display("FAIL alt_gnt%0d: gnt=%b required %b", i, {gnt_0, gnt_1}, exp_g);
            else pass++;
            if (i > 0) begin
                chk++;
                if (i % 2 == 1) begin
                    if ({rvalid_0, rvalid_1} !== 2'b10 || rdata_0 !== 32'h11111111 || rdata_1 !== 32'h0)
                        $display("FAIL alt_resp%0d: rv=%b d0=%h d1=%h required 10 11111111 0",
                                 i, {rvalid_0, rvalid_1}, rdata_0, rdata_1);
                    else pass++;
                end else begin
                    if ({rvalid_0, rvalid_1} !== 2'b01 || rdata_1 !== 32'h22222222 || rdata_0 !== 32'h0)
                        $display("FAIL alt_resp%0d: rv=%b d0=%h d1=%h required 01 0 22222222",
                                 i, {rvalid_0, rvalid_1}, rdata_0, rdata_1);
                    else pass++;
                end
            end
            tick;
        end
        idle;
        #1;
        chk++;
        if ({rvalid_0, rvalid_1} !== 2'b01 || rdata_1 !== 32'h22222222 || {gnt_0, gnt_1} !== 2'b00)
            $display("FAIL alt_last: rv=%b d1=%h gnt=%b required 01 22222222 00",
                     {rvalid_0, rvalid_1}, rdata_1, {gnt_0, gnt_1});
        else pass++;
        tick;
        chk++;
        if ({rvalid_0, rvalid_1} !== 2'b00) $display("FAIL alt_quiet: rv=%b required 00", {rvalid_0, rvalid_1});
        else pass++;
    endtask

    task automatic test_byte_en;
        idle;
        req_0 = 1; we_0 = 1; addr_0 = 4'd5; wdata_0 = 32'h0; be_0 = 4'hF;
        tick; idle;
        req_1 = 1; we_1 = 1; addr_1 = 4'd5; wdata_1 = 32'hDDDDEEEE; be_1 = 4'b0011;
        #1;
        chk++;
        if ({gnt_1, mem_writeEnable, mem_writeByteEnable} !== 6'b11_0011)
            $display("FAIL be_write: gnt1/we/be=%b required 110011", {gnt_1, mem_writeEnable, mem_writeByteEnable});
        else pass++;
        tick; idle;
        req_0 = 1; we_0 = 1; addr_0 = 4'd5; wdata_0 = 32'hFFFFFFFF; be_0 = 4'b0000;
        #1;
        chk++;
        if ({gnt_0, mem_writeEnable, mem_writeByteEnable} !== 6'b11_0000)
            $display("FAIL be_zero_write: gnt0/we/be=%b required 110000", {gnt_0, mem_writeEnable, mem_writeByteEnable});
        else pass++;
        tick; idle;
        req_1 = 1; addr_1 = 4'd5;
        #1;
        chk++;
        if ({gnt_1, mem_readEnable, mem_writeEnable} !== 3'b110)
            $display("FAIL be_read_gnt: gnt1/re/we=%b required 110", {gnt_1, mem_readEnable, mem_writeEnable});
        else pass++;
        tick; idle;
        #1;
        chk++;
        if ({rvalid_0, rvalid_1} !== 2'b01 || rdata_1 !== 32'h0000EEEE || rdata_0 !== 32'h0)
            $display("FAIL be_read_data: rv=%b d1=%h d0=%h required 01 0000eeee 0",
                     {rvalid_0, rvalid_1}, rdata_1, rdata_0);
        else pass++;
        tick;
    endtask

    task automatic test_write_read;
        idle;
        req_0 = 1; we_0 = 1; addr_0 = 4'd3; wdata_0 = 32'hA5A5A5A5; be_0 = 4'hF;
        #1;
        chk++;
        if ({gnt_0, gnt_1, mem_writeEnable, mem_address} !== {3'b101, 4'd3})
            $display("FAIL wr_gnt: gnt0/gnt1/we=%b addr=%0d required 101 addr=3",
                     {gnt_0, gnt_1, mem_writeEnable}, mem_address);
        else pass++;
        tick;
        we_0 = 0;
        #1;
        chk++;
        if ({gnt_0, mem_readEnable, rvalid_0, rvalid_1} !== 4'b1100)
            $display("FAIL rd_gnt: gnt0/re/rv0/rv1=%b required 1100", {gnt_0, mem_readEnable, rvalid_0, rvalid_1});
        else pass++;
        tick; idle;
        #1;
        chk++;
        if ({rvalid_0, rvalid_1} !== 2'b10 || rdata_0 !== 32'hA5A5A5A5 || rdata_1 !== 32'h0)
            $display("FAIL rd_resp: rv=%b d0=%h d1=%h required 10 a5a5a5a5 0", {rvalid_0, rvalid_1}, rdata_0, rdata_1);
        else pass++;
        tick;
        chk++;
        if ({rvalid_0, rvalid_1} !== 2'b00) $display("FAIL rd_pulse_width: rv=%b required 00", {rvalid_0, rvalid_1});
        else pass++;
    endtask

    task automatic test_reset_mid_init;
        int cyc;
        idle;
        req_0 = 1; addr_0 = 4'd3;
        tick; idle;
        chk++;
        if (rvalid_0 !== 1'b1) $display("FAIL pre_reset_rvalid: rvalid_0=%b required 1", rvalid_0);
        else pass++;
        reset = 1;
        #1;
        chk++;
        if ({rvalid_0, init_done} !== 2'b00) $display("FAIL async_drop: rv0/done=%b required 00", {rvalid_0, init_done});
        else pass++;
        tick;
        reset = 0;
        repeat (7) tick;
        chk++;
        if (mem_address !== 4'd7 || mem_writeEnable !== 1'b1)
            $display("FAIL init_at7: addr=%0d we=%b required 7 1", mem_address, mem_writeEnable);
        else pass++;
        reset = 1;
        #1;
        chk++;
        if (mem_address !== 4'd0 || {rvalid_0, rvalid_1, init_done} !== 3'b000)
            $display("FAIL init_reset_clear: addr=%0d rv/done=%b required 0 000",
                     mem_address, {rvalid_0, rvalid_1, init_done});
        else pass++;
        tick;
        reset = 0;
        #1;
        chk++;
        if (mem_address !== 4'd0 || mem_writeEnable !== 1'b1)
            $display("FAIL init_restart: addr=%0d we=%b required 0 1", mem_address, mem_writeEnable);
        else pass++;
        wait_init(40, cyc);
        chk++;
        if (cyc !== 16) $display("FAIL init_restart_len: %0d cycles required 16", cyc);
        else pass++;
    endtask

    task automatic test_reset_mid_read;
        int pulses;
        int cyc;
        idle;
        req_1 = 1; addr_1 = 4'd2;
        #1;
        chk++;
        if (gnt_1 !== 1'b1) $display("FAIL mr_gnt: gnt_1=%b required 1", gnt_1);
        else pass++;
        #1;
        reset = 1;
        idle;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rvalid_1 || rvalid_0) pulses++;
            if (i == 1) reset = 0;
        end
        chk++;
        if (pulses !== 0) $display("FAIL mr_dropped: %0d rvalid pulses required 0", pulses);
        else pass++;
        wait_init(40, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle;
        test_reset;
        test_init;
        test_alternate;
        test_byte_en;
        test_write_read;
        test_reset_mid_init;
        test_reset_mid_read;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one port of dual_port_BRAM_byte_en between two requesters, e.g. an instruction-side and a data-side client of one core.
- Round-robin arbitration, one access per cycle, fixed 1-cycle read latency with per-requester response steering.
- Optional post-reset zero-fill sequencer; clients are stalled until memory is initialised.

Parameters:
- DATA_WIDTH, 32, data word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8, word address width; the memory holds 2^ADDR_WIDTH words
- INIT_MEM, 1, 1 = zero-fill every word after reset before granting; 0 = no fill

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- req_0 / req_1  in  1  access request
- we_0 / we_1  in  1  1 = write, 0 = read
- be_0 / be_1  in  DATA_WIDTH/8  write byte enables
- addr_0 / addr_1  in  ADDR_WIDTH  word address
- wdata_0 / wdata_1  in  DATA_WIDTH  write data
- gnt_0 / gnt_1  out  1  request accepted this cycle (combinational)
- rvalid_0 / rvalid_1  out  1  read data valid (1-cycle pulse)
- rdata_0 / rdata_1  out  DATA_WIDTH  read data
- init_done  out  1  high once the arbiter is servicing requests
- mem_readEnable  out  1  to BRAM readEnable
- mem_writeEnable  out  1  to BRAM writeEnable
- mem_writeByteEnable  out  DATA_WIDTH/8  to BRAM writeByteEnable
- mem_address  out  ADDR_WIDTH  to BRAM address
- mem_writeData  out  DATA_WIDTH  to BRAM writeData
- mem_readData  in  DATA_WIDTH  from BRAM readData (registered, valid 1 cycle after the read)

Behaviour:
- Reset values (asynchronous): state = INIT, init_cnt = 0, last_gnt = 1, rvalid_0/1 = 0, init_done = 0, pending-read tag = none.
- FSM states:
  - INIT: if INIT_MEM = 1, drive mem_writeEnable = 1, all byte enables set, mem_writeData = 0, mem_address = init_cnt, mem_readEnable = 0, gnt_0/1 = 0. init_cnt increments each cycle. After writing address 2^ADDR_WIDTH-1, go to RUN; the counter has ADDR_WIDTH+1 bits, so no wrap-around ambiguity. If INIT_MEM = 0, INIT lasts exactly one cycle with no memory access.
  - RUN: init_done = 1. Arbitrate every cycle. No transition out of RUN except on reset.
- Arbitration:
  - Only req_0 high -> grant 0. Only req_1 high -> grant 1. Both high -> grant the requester not equal to last_gnt.
  - last_gnt updates only on a cycle in which a grant is issued.
  - At most one gnt is high in any cycle. gnt_x = req_x & selected & (state == RUN).
- Memory drive:
  - Selected requester's fields are muxed combinationally onto the mem_* outputs.
  - mem_readEnable = granted & ~we; mem_writeEnable = granted & we.
  - With no grant, all mem enables are 0; address, data and byte enables are don't-care but held at requester 0's values to limit toggling.
- Read response:
  - A granted read sets a 1-bit tag register; on the next cycle rvalid_<tag> = 1 for exactly one cycle and rdata_<tag> = mem_readData.
  - rdata of the non-responding requester is driven to 0.
  - Back-to-back reads, alternating or from the same requester, sustain one response per cycle.
- Writes produce no rvalid. A write whose byte enables are all zero is still granted and is a no-op in memory.
- Requester obligations: hold req and its fields stable until gnt. A request may be withdrawn before gnt without side effects.
- A read and write to the same address in consecutive cycles return the post-write data; ordering is strictly grant order.
- Reset asserted mid-INIT or mid-read:
  - Asynchronously clears all state; in-flight rvalid is dropped.
  - INIT restarts at address 0 after reset deasserts.

Test Plan:
- INIT_MEM=1, ADDR_WIDTH=4: release reset -> exactly 16 cycles of mem_writeEnable=1 with addresses 0..15 and data 0; init_done rises the cycle after address 15; no gnt during INIT.
- Req_0 writes addr 3 = 32'hA5A5A5A5 with be=4'b1111, then reads addr 3 -> gnt_0 on both cycles; rvalid_0 one cycle after the read grant with rdata_0 = 32'hA5A5A5A5; rvalid_1 stays 0.
- req_0 and req_1 both held high for 4 reads (addrs 1 and 2) -> grants alternate 0,1,0,1 starting with 0; each rvalid pulse lands on the matching requester 1 cycle after its grant.
- Byte-enable write: addr 5 = 0, then req_1 writes 32'hDDDDEEEE with be=4'b0011, then reads -> rdata_1 = 32'h0000EEEE.
- Reset pulsed while INIT is at address 7 -> rvalid/init_done drop to 0 immediately; after release, INIT resumes from address 0.
- Read by req_1 granted, then reset asserted before the response cycle -> no rvalid_1 pulse is produced.
